mem_access_ctrl: RTL and testbench

- Sequences the data-memory access for the instruction held in the EXE/MEM pipeline register.
- Drives a req/ack handshake to a variable-latency data memory.
- Freezes the upstream pipeline with a stall signal while the access is outstanding.
- Owns the MEM/WB register: write-back fields, with bubble insertion on stall cycles.

---
 rtl/mem_access_ctrl.sv | 74 +++++++
 tb/tb_mem_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: EXE/MEM data-memory sequencer with req/ack handshake, pipeline stall and MEM/WB register.
// Optional access timeout and sticky err flag enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memRead_in,
    input  logic             memWrite_in,
    input  logic             memtoReg_in,
    input  logic             wen_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [DSIZE-1:0] alu_in,
    input  logic [DSIZE-1:0] rdata2_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             stall,
    output logic             wen_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [DSIZE-1:0] wb_data_out,
    output logic             err,
    output logic [CNTW-1:0]  stall_cnt
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic op, abort;
    assign op        = memRead_in | memWrite_in;
    assign mem_req   = !rst && (state == WAIT || op);
    assign mem_we    = mem_req & memWrite_in;
    assign mem_addr  = alu_in;
    assign mem_wdata = rdata2_in;
    assign stall     = mem_req && !mem_ack && !abort;
`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) > 0 ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] wait_cnt;
    // an ack on the last allowed cycle wins over the abort
    assign abort = state == WAIT && wait_cnt == TW'(TIMEOUT - 1) && !mem_ack;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (abort) err <= 1'b1;
        end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            wen_out     <= 1'b0;
            waddr_out   <= '0;
            wb_data_out <= '0;
            stall_cnt   <= '0;
        end else begin
            // stalled means the access is still outstanding, in either state
            state   <= stall ? WAIT : IDLE;
            wen_out <= !stall && !abort && wen_in;
            if (!stall) begin
                waddr_out   <= waddr_in;
                wb_data_out <= (memtoReg_in && memRead_in && !memWrite_in) ? mem_rdata : alu_in;
            end
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
    localparam int CNTW = 4;
    localparam int SAT  = (1 << CNTW) - 1;
    logic        clk = 0, rst = 1;
    logic        memRead_in = 0, memWrite_in = 0, memtoReg_in = 0, wen_in = 0;
    logic [4:0]  waddr_in = 0;
    logic [31:0] alu_in = 0, rdata2_in = 0, mem_rdata = 0;
    logic        mem_ack = 0;
    logic        mem_req, mem_we, stall, wen_out, err;
    logic [31:0] mem_addr, mem_wdata, wb_data_out;
    logic [4:0]  waddr_out;
    logic [CNTW-1:0] stall_cnt;
    int errors = 0, checks = 0, exp_cnt = 0;

    mem_access_ctrl #(.DSIZE(32), .ASIZE(5), .TIMEOUT(4), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .memtoReg_in(memtoReg_in), .wen_in(wen_in), .waddr_in(waddr_in), .alu_in(alu_in),
        .rdata2_in(rdata2_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .wen_out(wen_out), .waddr_out(waddr_out), .wb_data_out(wb_data_out), .err(err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // One instruction held in EXE/MEM until the memory acks after lat wait cycles.
    task automatic do_access(input logic rd, wr, m2r, we, input logic [4:0] wa,
                             input logic [31:0] alu, wd, rdat, input int lat);
        logic o;
        int l;
        logic [31:0] exp_data;
        o = rd | wr;
        l = o ? lat : 0;
        for (int k = 0; k <= l; k++) begin
            memRead_in = rd; memWrite_in = wr; memtoReg_in = m2r; wen_in = we;
            waddr_in = wa; alu_in = alu; rdata2_in = wd;
            mem_ack = o ? (k == l) : 1'($urandom_range(0, 1));
            mem_rdata = (k == l) ? rdat : $urandom;
            #1;
            checks++;
            if (mem_req !== o || stall !== (o && k < l)) begin
                errors++;
                $display("FAIL req_stall cycle %0d: mem_req=%b stall=%b, required %b %b", k, mem_req, stall, o, o && k < l);
            end
            if (o) begin
                checks++;
                if (mem_we !== wr || mem_addr !== alu || mem_wdata !== wd) begin
                    errors++;
                    $display("FAIL mem_bus: we=%b addr=%h wdata=%h, required %b %h %h", mem_we, mem_addr, mem_wdata, wr, alu, wd);
                end
            end
            @(posedge clk); #1;
            if (k < l) begin
                checks++;
                if (wen_out !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble: wen_out=%b, required 0", wen_out);
                end
            end
        end
        exp_cnt = (exp_cnt + l > SAT) ? SAT : exp_cnt + l;
        exp_data = (m2r && rd && !wr) ? rdat : alu;
        checks++;
        if (wen_out !== we || waddr_out !== wa || wb_data_out !== exp_data) begin
            errors++;
            $display("FAIL writeback: wen=%b waddr=%0d data=%h, required %b %0d %h", wen_out, waddr_out, wb_data_out, we, wa, exp_data);
        end
        checks++;
        if (stall_cnt !== CNTW'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset;
        memRead_in = 1;
        #1;
        checks++;
        if (mem_req !== 0 || stall !== 0 || wen_out !== 0 || waddr_out !== 0 || wb_data_out !== 0 || err !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL reset: req=%b stall=%b wen=%b waddr=%0d data=%h err=%b cnt=%0d, required all 0",
                     mem_req, stall, wen_out, waddr_out, wb_data_out, err, stall_cnt);
        end
        memRead_in = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_load;
        do_access(1, 0, 1, 1, 5'd3, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_store_3cycle;
        do_access(0, 1, 0, 0, 5'd9, 32'h20, 32'h55, 32'h12345678, 3);
    endtask

    task automatic test_back_to_back;
        do_access(1, 0, 1, 1, 5'd4, 32'h40, 32'h0, 32'hAAAA0001, 1);
        do_access(1, 0, 1, 1, 5'd6, 32'h44, 32'h0, 32'hBBBB0002, 1);
    endtask

    task automatic test_alu_op;
        do_access(0, 0, 0, 1, 5'd7, 32'h7, 32'h0, 32'hFFFFFFFF, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 80; i++)
            do_access(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                      $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_mid_wait;
        memRead_in = 1; memWrite_in = 0; memtoReg_in = 1; wen_in = 1; waddr_in = 5'd12; alu_in = 32'h80; mem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1 || stall !== 1) begin
            errors++;
            $display("FAIL wait_before_rst: req=%b stall=%b, required 1 1", mem_req, stall);
        end
        rst = 1;
        #1;
        checks++;
        if (mem_req !== 0 || stall !== 0 || wen_out !== 0 || waddr_out !== 0 || wb_data_out !== 0 || err !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL async_reset: req=%b stall=%b wen=%b waddr=%0d data=%h err=%b cnt=%0d, required all 0",
                     mem_req, stall, wen_out, waddr_out, wb_data_out, err, stall_cnt);
        end
        memRead_in = 0; wen_in = 0;
        #1 rst = 0;
        exp_cnt = 0;
        @(posedge clk); #1;
        do_access(1, 0, 1, 1, 5'd13, 32'h84, 32'h0, 32'hC0FFEE00, 1);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        for (int k = 0; k <= 4; k++) begin
            memRead_in = 1; memWrite_in = 0; memtoReg_in = 1; wen_in = 1; waddr_in = 5'd17; alu_in = 32'h90; mem_ack = 0;
            #1;
            checks++;
            if (mem_req !== 1 || stall !== (k < 4)) begin
                errors++;
                $display("FAIL timeout_cycle %0d: req=%b stall=%b, required 1 %b", k, mem_req, stall, k < 4);
            end
            @(posedge clk); #1;
        end
        exp_cnt = (exp_cnt + 4 > SAT) ? SAT : exp_cnt + 4;
        checks++;
        if (wen_out !== 0 || err !== 1) begin
            errors++;
            $display("FAIL abort: wen_out=%b err=%b, required 0 1", wen_out, err);
        end
        do_access(0, 0, 0, 1, 5'd2, 32'h33, 32'h0, 32'h0, 0);
        checks++;
        if (err !== 1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask
`else
    task automatic test_long_wait;
        do_access(1, 0, 1, 1, 5'd21, 32'hA0, 32'h0, 32'h0BADF00D, 12);
        checks++;
        if (err !== 0) begin
            errors++;
            $display("FAIL err_tied: err=%b, required 0", err);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_zero_wait_load;
        test_store_3cycle;
        test_back_to_back;
        test_alu_op;
        test_random;
        test_reset_mid_wait;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`else
        test_long_wait;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
